// File: rtl/bus_nxn_pkg.sv
// Shared types and helpers for the N-device parallel bus: FSM states, destination
// ID extraction and index-width sizing.
package bus_nxn_pkg;

  typedef enum logic {ARB, SEND} state_t;

  localparam int ID_W     = 8;
  localparam int MAX_BITS = 512;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Destination ID sits in the top ID_W bits of a packet that is `bits` wide.
  function automatic logic [ID_W-1:0] dst_of(input logic [MAX_BITS-1:0] pkt, input int bits);
    return pkt[bits-1 -: ID_W];
  endfunction

endpackage

// File: rtl/bus_fifo_full.sv
// Synchronous show-ahead FIFO used for every ingress and egress queue; push when
// full and pop when empty are ignored.
module bus_fifo_full
  import bus_nxn_pkg::*;
#(
  parameter int depth = 4,
  parameter int bits  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [bits-1:0]            Din,
  output logic [bits-1:0]            Dout,
  output logic                       pndng,
  output logic                       full,
  output logic [$clog2(depth+1)-1:0] count
);

  localparam int PTR_W = idx_w(depth);
  localparam int CNT_W = $clog2(depth + 1);

  logic [bits-1:0]  mem_q [depth];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wr_en, rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(depth - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pndng = (cnt_q != '0);
  assign full  = (cnt_q == CNT_W'(depth));
  assign count = cnt_q;
  assign wr_en = push && !full;
  assign rd_en = pop && pndng;
  assign Dout  = pndng ? mem_q[rd_ptr_q] : '0;

  // NOTE: state registers use <= so every flop samples pre-edge values; blocking
  // assignments here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  // NOTE: the storage array is deliberately not reset; validity comes from the
  // pointers and count, and Dout is gated by pndng so stale words never show.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= Din;
  end

endmodule

// File: rtl/prll_bus_nxn.sv
// N-device shared parallel bus: per-device ingress/egress FIFOs and a round-robin
// ARB/SEND arbiter moving one packet (unicast, broadcast or dropped) per transaction.
module prll_bus_nxn
  import bus_nxn_pkg::*;
#(
  parameter int              drvrs = 4,
  parameter int              bits  = 32,
  parameter int              depth = 4,
  parameter logic [ID_W-1:0] bdcst = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [drvrs-1:0]      push,
  input  logic [drvrs*bits-1:0] D_push,
  input  logic [drvrs-1:0]      pop,
  output logic [drvrs*bits-1:0] D_pop,
  output logic [drvrs-1:0]      pndng,
  output logic [drvrs-1:0]      full,
  output logic [drvrs-1:0]      ovf,
  output logic [15:0]           drop_cnt
);

  localparam int IDX_W = idx_w(drvrs);
  localparam int CNT_W = $clog2(depth + 1);

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             rr_q, rr_d, grant_q, grant_d, gnt;
  logic [bits-1:0]              bus_q, bus_d;
  logic [15:0]                  drop_q, drop_d;
  logic [drvrs-1:0]             ovf_q;
  logic [drvrs-1:0]             in_ne, in_pop, eg_full, eg_push, elig, others_ok;
  logic [drvrs-1:0][bits-1:0]   in_head;
  logic [drvrs-1:0][ID_W-1:0]   head_dst;
  logic [drvrs-1:0][CNT_W-1:0]  in_cnt, eg_cnt;
  logic [ID_W-1:0]              bus_dst;
  logic                         found;
  logic                         unused_cnt;

  for (genvar i = 0; i < drvrs; i++) begin : g_dev
    bus_fifo_full #(.depth(depth), .bits(bits)) u_ingress (
      .clk(clk), .reset(reset), .push(push[i]), .pop(in_pop[i]),
      .Din(D_push[i*bits +: bits]), .Dout(in_head[i]), .pndng(in_ne[i]),
      .full(full[i]), .count(in_cnt[i])
    );
    bus_fifo_full #(.depth(depth), .bits(bits)) u_egress (
      .clk(clk), .reset(reset), .push(eg_push[i]), .pop(pop[i]),
      .Din(bus_q), .Dout(D_pop[i*bits +: bits]), .pndng(pndng[i]),
      .full(eg_full[i]), .count(eg_cnt[i])
    );
    assign head_dst[i]  = dst_of(MAX_BITS'(in_head[i]), bits);
    assign others_ok[i] = &(~eg_full | (drvrs'(1) << i));
  end

  assign unused_cnt = ^{in_cnt, eg_cnt};
  assign bus_dst    = dst_of(MAX_BITS'(bus_q), bits);
  assign ovf        = ovf_q;
  assign drop_cnt   = drop_q;

  // Invalid destinations stay eligible so they drain into the drop counter.
  always_comb begin
    elig = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (in_ne[i]) begin
        if (int'(head_dst[i]) < drvrs) elig[i] = ~eg_full[head_dst[i][IDX_W-1:0]];
        else if (head_dst[i] == bdcst) elig[i] = others_ok[i];
        else                           elig[i] = 1'b1;
      end
    end
  end

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= drvrs) s -= drvrs;
    return IDX_W'(s);
  endfunction

  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < drvrs; k++) begin
      if (!found && elig[wrap_idx(rr_q, k)]) begin
        found = 1'b1;
        gnt   = wrap_idx(rr_q, k);
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through the
  // case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    bus_d   = bus_q;
    rr_d    = rr_q;
    drop_d  = drop_q;
    in_pop  = '0;
    eg_push = '0;
    case (state_q)
      ARB: begin
        if (found) begin
          grant_d = gnt;
          bus_d   = in_head[gnt];
          state_d = SEND;
        end
      end
      SEND: begin
        in_pop[grant_q] = 1'b1;
        if (int'(bus_dst) < drvrs)  eg_push[bus_dst[IDX_W-1:0]] = 1'b1;
        else if (bus_dst == bdcst)  eg_push = ~(drvrs'(1) << grant_q);
        else if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        rr_d    = (grant_q == IDX_W'(drvrs - 1)) ? '0 : grant_q + IDX_W'(1);
        state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ARB;
      rr_q    <= '0;
      grant_q <= '0;
      bus_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      bus_q   <= bus_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_q | (push & full);
    end
  end

endmodule
